// File: rtl/pipe_core.sv
// pipe_core: four-stage IF/ID/EX/WB integer pipeline with an 8-op ALU and NUM_REGS x DATA_W register file.
// Define PIPE_CORE_FORWARD_EN to bypass ID operands from EX and WB; otherwise ID interlocks on hazards.
module pipe_core #(
  parameter  int DATA_W   = 32,
  parameter  int NUM_REGS = 4,
  localparam int RA_W     = $clog2(NUM_REGS),
  localparam int INSTR_W  = 4 + 2 * RA_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               hold,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instr,
  output logic               instr_ready,
  output logic               wb_valid,
  output logic [RA_W-1:0]    wb_addr,
  output logic [DATA_W-1:0]  wb_data,
  input  logic [RA_W-1:0]    dbg_addr,
  output logic [DATA_W-1:0]  dbg_data,
  output logic [15:0]        retire_count
);

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_INC = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_MOV = 3'b111;

  logic [DATA_W-1:0] rf [NUM_REGS];

  // IF/ID
  logic               ifid_valid;
  logic [INSTR_W-1:0] ifid_instr;

  // ID/EX
  logic              idex_valid;
  logic [2:0]        idex_op;
  logic [RA_W-1:0]   idex_rd;
  logic [DATA_W-1:0] idex_a;
  logic [DATA_W-1:0] idex_b;

  // EX/WB
  logic              exwb_valid;
  logic [2:0]        exwb_op;
  logic [RA_W-1:0]   exwb_rd;
  logic [DATA_W-1:0] exwb_data;

  logic              id_mode;
  logic [2:0]        id_op;
  logic [RA_W-1:0]   id_rd;
  logic [RA_W-1:0]   id_rs;
  logic [DATA_W-1:0] id_imm;
  logic [DATA_W-1:0] id_a;
  logic [DATA_W-1:0] id_b_reg;
  logic [DATA_W-1:0] id_b;
  logic [DATA_W-1:0] ex_result;
  logic              idex_writes;
  logic              exwb_writes;
  logic              stall;

  assign id_mode = ifid_instr[INSTR_W-1];
  assign id_op   = ifid_instr[INSTR_W-2 -: 3];
  assign id_rd   = ifid_instr[2*RA_W-1 -: RA_W];
  assign id_rs   = ifid_instr[RA_W-1:0];
  assign id_imm  = {{(DATA_W-RA_W){1'b0}}, id_rs};

  assign idex_writes = idex_valid && (idex_op != OP_NOP);
  assign exwb_writes = exwb_valid && (exwb_op != OP_NOP);

  always_comb begin
    ex_result = '0;
    case (idex_op)
      OP_ADD:  ex_result = idex_a + idex_b;
      OP_SUB:  ex_result = idex_a - idex_b;
      OP_INC:  ex_result = idex_a + DATA_W'(1);
      OP_AND:  ex_result = idex_a & idex_b;
      OP_OR:   ex_result = idex_a | idex_b;
      OP_XOR:  ex_result = idex_a ^ idex_b;
      OP_MOV:  ex_result = idex_b;
      default: ex_result = '0;
    endcase
  end

`ifdef PIPE_CORE_FORWARD_EN
  // The youngest producer wins: EX result beats the value waiting in WB.
  always_comb begin
    id_a = rf[id_rd];
    if (idex_writes && (idex_rd == id_rd))
      id_a = ex_result;
    else if (exwb_writes && (exwb_rd == id_rd))
      id_a = exwb_data;

    id_b_reg = rf[id_rs];
    if (idex_writes && (idex_rd == id_rs))
      id_b_reg = ex_result;
    else if (exwb_writes && (exwb_rd == id_rs))
      id_b_reg = exwb_data;
  end

  assign stall = 1'b0;
`else
  logic uses_a;
  logic uses_b;
  logic hazard_a;
  logic hazard_b;

  assign id_a     = rf[id_rd];
  assign id_b_reg = rf[id_rs];

  assign uses_a = (id_op != OP_NOP) && (id_op != OP_MOV);
  assign uses_b = !id_mode && (id_op != OP_NOP) && (id_op != OP_INC);

  assign hazard_a = uses_a && ((idex_writes && (idex_rd == id_rd)) ||
                               (exwb_writes && (exwb_rd == id_rd)));
  assign hazard_b = uses_b && ((idex_writes && (idex_rd == id_rs)) ||
                               (exwb_writes && (exwb_rd == id_rs)));

  assign stall = ifid_valid && (hazard_a || hazard_b);
`endif

  assign id_b        = id_mode ? id_imm : id_b_reg;
  assign instr_ready = !hold && !stall;

  assign wb_valid = exwb_writes;
  assign wb_addr  = exwb_rd;
  assign wb_data  = exwb_data;
  assign dbg_data = rf[dbg_addr];

  always_ff @(posedge clk) begin
    if (reset) begin
      ifid_valid   <= 1'b0;
      ifid_instr   <= '0;
      idex_valid   <= 1'b0;
      idex_op      <= OP_NOP;
      idex_rd      <= '0;
      idex_a       <= '0;
      idex_b       <= '0;
      exwb_valid   <= 1'b0;
      exwb_op      <= OP_NOP;
      exwb_rd      <= '0;
      exwb_data    <= '0;
      retire_count <= '0;
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
    end else if (!hold) begin
      if (!stall) begin
        // instr_ready is high here, so instr_valid alone decides the transfer
        ifid_valid <= instr_valid;
        ifid_instr <= instr;
        idex_valid <= ifid_valid;
        idex_op    <= id_op;
        idex_rd    <= id_rd;
        idex_a     <= id_a;
        idex_b     <= id_b;
      end else begin
        idex_valid <= 1'b0;
      end

      exwb_valid <= idex_valid;
      exwb_op    <= idex_op;
      exwb_rd    <= idex_rd;
      exwb_data  <= ex_result;

      if (exwb_valid) retire_count <= retire_count + 16'd1;
      if (exwb_writes) rf[exwb_rd] <= exwb_data;
    end
  end

endmodule
